// File: rtl/gsensor_spi_slave.sv
// SPI responder emulating an ADXL345-style register map (mode 3, 3- or 4-wire readback).
// Serves parallel axis samples through registers 0x32-0x37 and raises data-ready on INT2.
module gsensor_spi_slave #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSPI_CSN,
    input  logic        iSPI_CLK,
    input  logic        iSPI_SDI,
    output logic        oSPI_SDO,
    output logic        oSPI_SDO_OE,
    output logic        oSPI_SDIO,
    output logic        oSPI_SDIO_OE,
    input  logic        iSAMPLE,
    input  logic [15:0] iX,
    input  logic [15:0] iY,
    input  logic [15:0] iZ,
    output logic        oINT2,
    output logic        oBUSY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } state_t;

    localparam int CFG_REGS = 19;
    localparam logic [4:0] IDX_INT_ENABLE = 5'd17;
    localparam logic [4:0] IDX_INT_MAP    = 5'd18;

    // Index into the 0x1D..0x2F block; the block spans fewer than 32 addresses so 5-bit modular math is exact
    function automatic logic [4:0] cfg_idx(input logic [5:0] addr);
        return addr[4:0] - 5'h1D;
    endfunction

    function automatic logic in_cfg(input logic [5:0] addr);
        return (addr >= 6'h1D) && (addr <= 6'h2F);
    endfunction

    function automatic logic in_axis(input logic [5:0] addr);
        return (addr >= 6'h32) && (addr <= 6'h37);
    endfunction

    logic [1:0]  csn_sync_r, sclk_sync_r, sdi_sync_r;
    logic        csn_d_r, sclk_d_r;
    logic        csn_s, sclk_s, sdi_s;
    logic        sclk_rise_s, sclk_fall_s, csn_fall_s;

    state_t      state_r, state_nxt_s;
    logic [2:0]  bit_cnt_r;
    logic [6:0]  rx_shift_r;
    logic [7:0]  rx_byte_s;
    logic [7:0]  tx_shift_r;
    logic        cmd_mb_r;
    logic [5:0]  addr_r, addr_nxt_s, load_addr_s;
    logic        byte_done_s, load_rd_s, wr_en_s;
    logic [7:0]  rd_byte_s;

    logic [7:0]  cfg_r [0:CFG_REGS-1];
    logic [7:0]  data_format_r, fifo_ctl_r, reg_39_r;

    logic [15:0] x_r, y_r, z_r;
    logic [15:0] pend_x_r, pend_y_r, pend_z_r;
    logic        pend_r, dr_r, dr_set_s, dr_clr_s;

    logic        busy_r, sdo_r, sdo_oe_r, sdio_r, sdio_oe_r, int2_r;

    // Two-flop synchronizers plus one delay stage for edge detection
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            csn_sync_r  <= 2'b11;
            sclk_sync_r <= 2'b11;
            sdi_sync_r  <= 2'b00;
            csn_d_r     <= 1'b1;
            sclk_d_r    <= 1'b1;
        end else begin
            csn_sync_r  <= {csn_sync_r[0], iSPI_CSN};
            sclk_sync_r <= {sclk_sync_r[0], iSPI_CLK};
            sdi_sync_r  <= {sdi_sync_r[0], iSPI_SDI};
            csn_d_r     <= csn_sync_r[1];
            sclk_d_r    <= sclk_sync_r[1];
        end
    end

    assign csn_s       = csn_sync_r[1];
    assign sclk_s      = sclk_sync_r[1];
    assign sdi_s       = sdi_sync_r[1];
    assign sclk_rise_s = sclk_s & ~sclk_d_r;
    assign sclk_fall_s = ~sclk_s & sclk_d_r;
    assign csn_fall_s  = ~csn_s & csn_d_r;

    // Byte-level decode shared by the FSM, the register file and the data-ready logic
    always_comb begin
        rx_byte_s   = {rx_shift_r, sdi_s};
        byte_done_s = sclk_rise_s && (bit_cnt_r == 3'd7) && (state_r != ST_IDLE) && !csn_s;
        addr_nxt_s  = cmd_mb_r ? (addr_r + 6'd1) : addr_r;
        if (state_r == ST_CMD) begin
            load_addr_s = rx_byte_s[5:0];
            load_rd_s   = byte_done_s && rx_byte_s[7];
        end else begin
            load_addr_s = addr_nxt_s;
            load_rd_s   = byte_done_s && (state_r == ST_RD);
        end
        wr_en_s  = byte_done_s && (state_r == ST_WR);
        dr_clr_s = byte_done_s && (state_r == ST_RD) && in_axis(addr_r);
    end

    // Next-state logic; a deasserted chip select always returns to idle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (csn_fall_s) state_nxt_s = ST_CMD;
                else            state_nxt_s = ST_IDLE;
            end
            ST_CMD: begin
                if (csn_s)            state_nxt_s = ST_IDLE;
                else if (byte_done_s) state_nxt_s = rx_byte_s[7] ? ST_RD : ST_WR;
                else                  state_nxt_s = ST_CMD;
            end
            ST_WR, ST_RD: begin
                if (csn_s) state_nxt_s = ST_IDLE;
                else       state_nxt_s = state_r;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state_r <= ST_IDLE;
        else      state_r <= state_nxt_s;
    end

    // Bit counter, shift registers and address pointer
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            bit_cnt_r  <= 3'd0;
            rx_shift_r <= 7'd0;
            tx_shift_r <= 8'd0;
            cmd_mb_r   <= 1'b0;
            addr_r     <= 6'd0;
        end else if (csn_s || (state_r == ST_IDLE)) begin
            bit_cnt_r  <= 3'd0;
            rx_shift_r <= 7'd0;
            tx_shift_r <= 8'd0;
        end else if (sclk_rise_s) begin
            bit_cnt_r  <= bit_cnt_r + 3'd1;
            rx_shift_r <= rx_byte_s[6:0];
            if (byte_done_s) begin
                if (state_r == ST_CMD) begin
                    cmd_mb_r <= rx_byte_s[6];
                    addr_r   <= rx_byte_s[5:0];
                end else begin
                    addr_r   <= addr_nxt_s;
                end
            end
            if (load_rd_s) tx_shift_r <= rd_byte_s;
        end else if (sclk_fall_s && (state_r == ST_RD)) begin
            tx_shift_r <= {tx_shift_r[6:0], 1'b0};
        end
    end

    // Read mux for the byte about to be loaded into the transmit shifter
    always_comb begin
        rd_byte_s = 8'h00;
        case (load_addr_s)
            6'h00:   rd_byte_s = DEVID;
            6'h30:   rd_byte_s = {dr_r, 7'b000_0000};
            6'h31:   rd_byte_s = data_format_r;
            6'h32:   rd_byte_s = x_r[7:0];
            6'h33:   rd_byte_s = x_r[15:8];
            6'h34:   rd_byte_s = y_r[7:0];
            6'h35:   rd_byte_s = y_r[15:8];
            6'h36:   rd_byte_s = z_r[7:0];
            6'h37:   rd_byte_s = z_r[15:8];
            6'h38:   rd_byte_s = fifo_ctl_r;
            6'h39:   rd_byte_s = reg_39_r;
            default: begin
                if (in_cfg(load_addr_s)) rd_byte_s = cfg_r[cfg_idx(load_addr_s)];
                else                     rd_byte_s = 8'h00;
            end
        endcase
    end

    // Writable register file; commits only on a complete data byte
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < CFG_REGS; i++) begin
                cfg_r[i] <= (i == 15) ? BW_RATE_RST : 8'h00;
            end
            data_format_r <= 8'h00;
            fifo_ctl_r    <= 8'h00;
            reg_39_r      <= 8'h00;
        end else if (wr_en_s) begin
            case (addr_r)
                6'h31:   data_format_r <= rx_byte_s;
                6'h38:   fifo_ctl_r    <= rx_byte_s;
                6'h39:   reg_39_r      <= rx_byte_s;
                default: begin
                    if (in_cfg(addr_r)) cfg_r[cfg_idx(addr_r)] <= rx_byte_s;
                end
            endcase
        end
    end

    assign dr_set_s = ~busy_r & (iSAMPLE | pend_r);

    // Axis snapshot: samples arriving mid-transaction are parked until chip select releases
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            x_r      <= 16'h0000;
            y_r      <= 16'h0000;
            z_r      <= 16'h0000;
            pend_x_r <= 16'h0000;
            pend_y_r <= 16'h0000;
            pend_z_r <= 16'h0000;
            pend_r   <= 1'b0;
            dr_r     <= 1'b0;
        end else begin
            if (iSAMPLE && busy_r) begin
                pend_r   <= 1'b1;
                pend_x_r <= iX;
                pend_y_r <= iY;
                pend_z_r <= iZ;
            end else if (iSAMPLE) begin
                pend_r <= 1'b0;
                x_r    <= iX;
                y_r    <= iY;
                z_r    <= iZ;
            end else if (pend_r && !busy_r) begin
                pend_r <= 1'b0;
                x_r    <= pend_x_r;
                y_r    <= pend_y_r;
                z_r    <= pend_z_r;
            end
            if (dr_set_s)      dr_r <= 1'b1;
            else if (dr_clr_s) dr_r <= 1'b0;
        end
    end

    // Registered pin outputs
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            busy_r    <= 1'b0;
            sdo_oe_r  <= 1'b0;
            sdio_oe_r <= 1'b0;
            int2_r    <= 1'b0;
            sdo_r     <= 1'b0;
            sdio_r    <= 1'b0;
        end else begin
            busy_r    <= ~csn_s;
            sdo_oe_r  <= (state_r == ST_RD) & ~data_format_r[6];
            sdio_oe_r <= (state_r == ST_RD) & data_format_r[6];
            int2_r    <= dr_r & cfg_r[IDX_INT_ENABLE][7] & cfg_r[IDX_INT_MAP][7];
            if (csn_s || (state_r != ST_RD)) begin
                sdo_r  <= 1'b0;
                sdio_r <= 1'b0;
            end else if (sclk_fall_s) begin
                sdo_r  <= tx_shift_r[7] & ~data_format_r[6];
                sdio_r <= tx_shift_r[7] & data_format_r[6];
            end
        end
    end

    assign oBUSY        = busy_r;
    assign oSPI_SDO     = sdo_r;
    assign oSPI_SDO_OE  = sdo_oe_r;
    assign oSPI_SDIO    = sdio_r;
    assign oSPI_SDIO_OE = sdio_oe_r;
    assign oINT2        = int2_r;

endmodule

// File: tb/tb_gsensor_spi_slave.sv
// Bench for gsensor_spi_slave: an SPI master model with a queue of expected read bytes,
// a table of single-byte register transactions and hand-written multi-cycle sequences.
module tb_gsensor_spi_slave;

    logic        iCLK, iRST, iSPI_CSN, iSPI_CLK, iSPI_SDI, iSAMPLE;
    logic [15:0] iX, iY, iZ;
    logic        oSPI_SDO, oSPI_SDO_OE, oSPI_SDIO, oSPI_SDIO_OE, oINT2, oBUSY;

    int          n_cmp, n_err;
    logic [7:0]  exp_q [$];
    logic [7:0]  wr_q  [$];

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] wdata;
        logic [7:0] exp;
        bit         three;
    } vec_t;

    vec_t vecs [19];

    gsensor_spi_slave dut (
        .iCLK(iCLK), .iRST(iRST), .iSPI_CSN(iSPI_CSN), .iSPI_CLK(iSPI_CLK),
        .iSPI_SDI(iSPI_SDI), .oSPI_SDO(oSPI_SDO), .oSPI_SDO_OE(oSPI_SDO_OE),
        .oSPI_SDIO(oSPI_SDIO), .oSPI_SDIO_OE(oSPI_SDIO_OE), .iSAMPLE(iSAMPLE),
        .iX(iX), .iY(iY), .iZ(iZ), .oINT2(oINT2), .oBUSY(oBUSY)
    );

    initial iCLK = 1'b0;
    always #10 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One SCLK period: drive on the falling edge, sample just before the rising edge
    task automatic spi_bit(input logic sdi, input bit three, output logic rd,
                           output logic s_oe, output logic d_oe);
        iSPI_CLK = 1'b0;
        iSPI_SDI = sdi;
        repeat (8) @(negedge iCLK);
        rd   = three ? oSPI_SDIO : oSPI_SDO;
        s_oe = oSPI_SDO_OE;
        d_oe = oSPI_SDIO_OE;
        iSPI_CLK = 1'b1;
        repeat (8) @(negedge iCLK);
    endtask

    // Returns {and(sdo_oe), or(sdo_oe), and(sdio_oe), or(sdio_oe)} over the bits sent
    task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit three,
                            output logic [7:0] rx, output logic [3:0] oes);
        logic rd, s_oe, d_oe;
        logic [7:0] shreg;
        shreg = tx;
        rx    = 8'h00;
        oes   = 4'b1010;
        for (int i = 0; i < nbits; i++) begin
            spi_bit(shreg[7], three, rd, s_oe, d_oe);
            shreg = {shreg[6:0], 1'b0};
            rx    = {rx[6:0], rd};
            oes   = {oes[3] & s_oe, oes[2] | s_oe, oes[1] & d_oe, oes[0] | d_oe};
        end
    endtask

    task automatic spi_txn(input logic [7:0] cmd, input int nbytes, input int last_bits,
                           input bit three);
        logic [7:0] rx, wd, exp;
        logic [3:0] oes;
        logic       e_s, e_d;
        iSPI_CSN = 1'b0;
        repeat (8) @(negedge iCLK);
        spi_byte(cmd, 8, three, rx, oes);
        chk("cmd_oe", 32'(oes), 32'(4'b0000));
        for (int b = 0; b < nbytes; b++) begin
            wd = 8'h00;
            if (!cmd[7] && wr_q.size() > 0) wd = wr_q.pop_front();
            spi_byte(wd, (b == nbytes - 1) ? last_bits : 8, three, rx, oes);
            if (cmd[7]) begin
                e_s = !three;
                e_d = three;
                chk("rd_oe", 32'(oes), 32'({e_s, e_s, e_d, e_d}));
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rd_data: got %0h but no expected byte queued", rx);
                end else begin
                    exp = exp_q.pop_front();
                    chk("rd_data", 32'(rx), 32'(exp));
                end
            end else begin
                chk("wr_oe", 32'(oes), 32'(4'b0000));
            end
        end
        repeat (8) @(negedge iCLK);
        iSPI_CSN = 1'b1;
        iSPI_CLK = 1'b1;
        repeat (8) @(negedge iCLK);
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        iX = x;
        iY = y;
        iZ = z;
        iSAMPLE = 1'b1;
        @(negedge iCLK);
        iSAMPLE = 1'b0;
    endtask

    initial begin
        logic [7:0] rx;
        logic [3:0] oes;

        n_cmp = 0;
        n_err = 0;
        vecs[0]  = '{8'h80, 8'h00, 8'hE5, 1'b0};   // DEVID
        vecs[1]  = '{8'hAC, 8'h00, 8'h0A, 1'b0};   // BW_RATE reset value
        vecs[2]  = '{8'h9E, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{8'h1D, 8'h5A, 8'h00, 1'b0};
        vecs[4]  = '{8'h9D, 8'h00, 8'h5A, 1'b0};
        vecs[5]  = '{8'h05, 8'hFF, 8'h00, 1'b0};   // unmapped: write ignored
        vecs[6]  = '{8'h85, 8'h00, 8'h00, 1'b0};
        vecs[7]  = '{8'h32, 8'h77, 8'h00, 1'b0};   // read-only axis byte
        vecs[8]  = '{8'hB2, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{8'hB0, 8'h00, 8'h00, 1'b0};   // INT_SOURCE, no sample yet
        vecs[10] = '{8'h2C, 8'h0F, 8'h00, 1'b0};
        vecs[11] = '{8'hAC, 8'h00, 8'h0F, 1'b0};
        vecs[12] = '{8'hB9, 8'h00, 8'h00, 1'b0};
        vecs[13] = '{8'h39, 8'hA5, 8'h00, 1'b0};
        vecs[14] = '{8'hB9, 8'h00, 8'hA5, 1'b0};
        vecs[15] = '{8'h31, 8'h40, 8'h00, 1'b0};   // switch to 3-wire
        vecs[16] = '{8'hB1, 8'h00, 8'h40, 1'b1};
        vecs[17] = '{8'h31, 8'h00, 8'h00, 1'b1};   // back to 4-wire
        vecs[18] = '{8'hB1, 8'h00, 8'h00, 1'b0};

        iRST = 1'b1; iSPI_CSN = 1'b1; iSPI_CLK = 1'b1; iSPI_SDI = 1'b0;
        iSAMPLE = 1'b0; iX = 16'h0000; iY = 16'h0000; iZ = 16'h0000;
        repeat (4) @(negedge iCLK);
        chk("reset_outs", 32'({oSPI_SDO, oSPI_SDO_OE, oSPI_SDIO, oSPI_SDIO_OE, oINT2, oBUSY}), 32'(6'b0));
        iRST = 1'b0;
        repeat (8) @(negedge iCLK);

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].cmd[7]) exp_q.push_back(vecs[i].exp);
            else                wr_q.push_back(vecs[i].wdata);
            spi_txn(vecs[i].cmd, 1, 8, vecs[i].three);
        end

        // Burst read of all axis bytes, then INT_SOURCE shows data-ready cleared
        pulse_sample(16'h1234, 16'hABCD, 16'h0F0F);
        exp_q.push_back(8'h80);
        spi_txn(8'hB0, 1, 8, 1'b0);
        exp_q.push_back(8'h34); exp_q.push_back(8'h12); exp_q.push_back(8'hCD);
        exp_q.push_back(8'hAB); exp_q.push_back(8'h0F); exp_q.push_back(8'h0F);
        spi_txn(8'hF2, 6, 8, 1'b0);
        exp_q.push_back(8'h00);
        spi_txn(8'hB0, 1, 8, 1'b0);

        // Interrupt gating by INT_ENABLE and INT_MAP
        wr_q.push_back(8'h80);
        spi_txn(8'h2E, 1, 8, 1'b0);
        pulse_sample(16'h5678, 16'h0001, 16'h0002);
        @(negedge iCLK);
        chk("int2_unmapped", 32'(oINT2), 32'(1'b0));
        wr_q.push_back(8'h80);
        spi_txn(8'h2F, 1, 8, 1'b0);
        chk("int2_mapped", 32'(oINT2), 32'(1'b1));
        exp_q.push_back(8'h78);
        spi_txn(8'hB2, 1, 8, 1'b0);
        chk("int2_cleared", 32'(oINT2), 32'(1'b0));
        pulse_sample(16'h0AA0, 16'h0BB0, 16'h0CC0);
        @(negedge iCLK);
        chk("int2_latency", 32'(oINT2), 32'(1'b1));

        // Coherence: a sample arriving mid-burst is held until chip select releases
        pulse_sample(16'h1111, 16'h1111, 16'h1111);
        for (int i = 0; i < 6; i++) exp_q.push_back(8'h11);
        fork
            spi_txn(8'hF2, 6, 8, 1'b0);
            begin
                repeat (200) @(negedge iCLK);
                pulse_sample(16'h2222, 16'h2222, 16'h2222);
            end
        join
        exp_q.push_back(8'h80);
        spi_txn(8'hB0, 1, 8, 1'b0);
        exp_q.push_back(8'h22);
        spi_txn(8'hB2, 1, 8, 1'b0);

        // Aborted write after 5 data bits leaves the register unchanged
        wr_q.push_back(8'hFF);
        spi_txn(8'h1E, 1, 5, 1'b0);
        exp_q.push_back(8'h00);
        spi_txn(8'h9E, 1, 8, 1'b0);

        // Address handling: MB=0 repeats, MB=1 wraps 0x3F -> 0x00
        exp_q.push_back(8'hE5); exp_q.push_back(8'hE5);
        spi_txn(8'h80, 2, 8, 1'b0);
        exp_q.push_back(8'h00); exp_q.push_back(8'hE5);
        spi_txn(8'hFF, 2, 8, 1'b0);

        // Reset in the middle of a DEVID read
        iSPI_CSN = 1'b0;
        repeat (8) @(negedge iCLK);
        spi_byte(8'h80, 8, 1'b0, rx, oes);
        iSPI_CLK = 1'b0;
        repeat (8) @(negedge iCLK);
        chk("pre_rst", 32'({oSPI_SDO, oSPI_SDO_OE, oBUSY}), 32'(3'b111));
        iRST = 1'b1;
        #1;
        chk("rst_mid", 32'({oSPI_SDO, oSPI_SDO_OE, oSPI_SDIO, oSPI_SDIO_OE, oINT2, oBUSY}), 32'(6'b0));
        iSPI_CLK = 1'b1;
        iSPI_CSN = 1'b1;
        repeat (4) @(negedge iCLK);
        iRST = 1'b0;
        repeat (8) @(negedge iCLK);
        exp_q.push_back(8'hE5);
        spi_txn(8'h80, 1, 8, 1'b0);
        exp_q.push_back(8'h0A);
        spi_txn(8'hAC, 1, 8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gsensor_spi_slave.md
# gsensor_spi_slave

Synthesizable SPI responder that emulates the accelerometer's register interface: it answers the SPI transactions issued by the sensor configuration/readback master with an ADXL345-compatible register map. It serves axis data supplied on parallel inputs, and raises the data-ready interrupt on INT2. It sits in place of the physical sensor on the GSENSOR_* pins, for board-level loopback and for closed-loop simulation of the SPI master. Both 4-wire (SDO) and 3-wire (shared SDIO) read-back are supported, selected by DATA_FORMAT bit 6.

## Interface
- DEVID, 8'hE5, value returned from address 0x00
- BW_RATE_RST, 8'h0A, reset value of register 0x2C
- iCLK  in  1  system clock (50 MHz); must be ≥16× SCLK frequency
- iRST  in  1  asynchronous, active-high reset
- iSPI_CSN  in  1  chip select, active low
- iSPI_CLK  in  1  SPI clock, mode 3 (idles high)
- iSPI_SDI  in  1  master data in (SDIO input in 3-wire mode)
- oSPI_SDO  out  1  read data, 4-wire mode
- oSPI_SDO_OE  out  1  output enable for oSPI_SDO
- oSPI_SDIO  out  1  read data, 3-wire mode
- oSPI_SDIO_OE  out  1  output enable for oSPI_SDIO
- iSAMPLE  in  1  one-cycle strobe: new axis sample valid
- iX, iY, iZ  in  16 each  two's-complement axis samples
- oINT2  out  1  data-ready interrupt, active high
- oBUSY  out  1  transaction in progress (synchronized CSN low)

## Operation
- Input sync: CSN, SCLK and SDI each pass through 2 flops; SCLK edges are detected from the synchronized copy. All logic runs in the iCLK domain.
- Bit order is MSB first. SDI is sampled on each SCLK rising edge. Read data changes on each SCLK falling edge.
- Command byte: bit7 = R/W (1 = read), bit6 = MB (multi-byte), bits5:0 = address.
- FSM states: IDLE, CMD, WR, RD.
  - IDLE→CMD on CSN falling.
  - CMD→WR or CMD→RD after the 8th rising edge.
  - WR and RD repeat per byte.
  - Any state→IDLE on CSN rising. Bit counter and shift register clear on that transition.
- Address after each byte: if MB=1, increment, wrapping 0x3F→0x00. If MB=0, unchanged.
- Write commit: the write happens only when the 8th bit of a data byte is captured. A partial byte is discarded.
- Register map (addresses not listed below read 0x00; writes to them are ignored):
  - 0x00: DEVID, read-only.
  - 0x1D–0x2F, 0x31, 0x38–0x39: read/write. Reset value 0x00, except 0x2C which resets to BW_RATE_RST.
  - 0x30: INT_SOURCE, read-only. Reads as {DATA_READY, 7'b0}.
  - 0x32–0x37: {X[7:0], X[15:8], Y[7:0], Y[15:8], Z[7:0], Z[15:8]}, read-only.
- Read byte load: the read shift register loads the addressed byte at the 8th rising edge of the command byte or of the previous data byte. Its MSB is driven on the following falling edge.
- Data snapshot: iSAMPLE copies iX/iY/iZ into the data registers and sets DATA_READY.
  - While oBUSY=1, an iSAMPLE is held as pending. It is applied on the cycle CSN deasserts.
  - A second pending iSAMPLE overwrites the captured values of the first.
- DATA_READY is cleared when a read byte from 0x32–0x37 completes. If a set occurs in the same cycle, set wins.
- oINT2 = DATA_READY & INT_ENABLE(0x2E)[7] & INT_MAP(0x2F)[7]. It is registered.
- Output enables:
  - oSPI_SDO_OE = 1 only in RD with DATA_FORMAT(0x31)[6]=0.
  - oSPI_SDIO_OE = 1 only in RD with DATA_FORMAT[6]=1.
  - Neither is asserted during CMD or WR.

## Timing
- Reset: every output is 0; FSM is IDLE; all registers take their reset values; pending sample cleared. Reset acts immediately, including mid-transaction.
- SCLK edge to internal action: 3 iCLK cycles (2 sync + 1 detect). Read data is valid ≤4 iCLK cycles after a falling edge.
- oBUSY and both OEs deassert ≤4 iCLK cycles after CSN rises.
- iSAMPLE to data registers and DATA_READY: 1 cycle when idle. oINT2 follows 1 cycle later.
- Completed write to 0x2E/0x2F takes effect on oINT2 at most 2 cycles after the commit.
- CSN low with no SCLK edges: stays in CMD; no side effects.

## Test plan
- Read DEVID: cmd 0x80 then 8 clocks → bits 0xE5 on oSPI_SDO. oSPI_SDO_OE high only for the data byte; oSPI_SDIO_OE stays 0.
- 3-wire: write 0x31=0x40, then cmd 0xB1 → 0x40 returned on oSPI_SDIO with oSPI_SDIO_OE=1. oSPI_SDO_OE stays 0.
- Burst read: iX=0x1234, iY=0xABCD, iZ=0x0F0F, then iSAMPLE; cmd 0xF2 plus 6 bytes → 34 12 CD AB 0F 0F. INT_SOURCE read afterwards = 0x00.
- Interrupt: write 0x2E=0x80 and 0x2F=0x80; iSAMPLE → oINT2=1 within 2 cycles. Reading 0x32 → oINT2=0 after that byte completes.
- Coherence:
  - Sample 0x1111 on all axes; start burst read at 0x32; pulse iSAMPLE with 0x2222 mid-read → all bytes read 0x11.
  - Next read returns 0x22; DATA_READY=1.
- Aborts:
  - Write to 0x1E with CSN raised after 5 data bits → 0x1E still 0x00.
  - Assert iRST mid-read → all outputs 0 in the same cycle; next DEVID read is correct.
